// File: rtl/axis_avg_pkg.sv
// Shared constants, FSM state type and saturating shift for axis_channel_averager.
// AXIS_AVG_TIMESTAMP_EN adds a block-counter word at the head of each packet.
package axis_avg_pkg;

    localparam int NUM_CH = 6;
`ifdef AXIS_AVG_TIMESTAMP_EN
    localparam int PKT_LEN = 7;
`else
    localparam int PKT_LEN = 6;
`endif
    localparam int ACC_W  = 48;
    localparam int OUT_W  = 32;
    localparam int BEAT_W = 3;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    function automatic logic [OUT_W-1:0] sat_shift(
        input logic signed [ACC_W-1:0] acc,
        input logic        [4:0]       shift
    );
        logic signed [ACC_W-1:0] s;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        s  = acc >>> shift;
        hi = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        lo = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
        if (s > hi) begin
            return hi[OUT_W-1:0];
        end else if (s < lo) begin
            return lo[OUT_W-1:0];
        end
        return s[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/axis_avg_lane.sv
// One channel: running accumulator plus the holding register read by the packet mux.
// The holding register only loads when the top level says the buffer is free.
module axis_avg_lane
    import axis_avg_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = OUT_W,
    parameter int ACC_WIDTH = ACC_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear,
    input  logic                 accept,
    input  logic                 complete,
    input  logic                 load,
    input  logic [4:0]           shift,
    input  logic [IN_WIDTH-1:0]  din,
    output logic [OUT_WIDTH-1:0] hold
);

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sum;

    assign sum = acc + {{(ACC_WIDTH-IN_WIDTH){din[IN_WIDTH-1]}}, din};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc  <= '0;
            hold <= '0;
        end else begin
            if (clear) begin
                acc <= '0;
            end else if (accept) begin
                acc <= complete ? '0 : sum;
            end
            if (accept && complete && load) begin
                hold <= OUT_WIDTH'(sat_shift(ACC_W'(sum), shift));
            end
        end
    end

endmodule

// File: rtl/axis_channel_averager.sv
// Block averager for six selected AXIS channels, double-buffered packet output.
// Optional AXIS_AVG_TIMESTAMP_EN prepends a 32-bit block counter word.
module axis_channel_averager
    import axis_avg_pkg::*;
#(
    parameter int SAXIS_TDATA_WIDTH = 32,
    parameter int MAXIS_TDATA_WIDTH = OUT_W,
    parameter int ACC_WIDTH         = ACC_W
) (
    input  logic                         a_clk,
    input  logic                         a_resetn,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_1_tdata,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_2_tdata,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_3_tdata,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_4_tdata,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_5_tdata,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_6_tdata,
    input  logic                         S_AXIS_1_tvalid,
    input  logic                         S_AXIS_2_tvalid,
    input  logic                         S_AXIS_3_tvalid,
    input  logic                         S_AXIS_4_tvalid,
    input  logic                         S_AXIS_5_tvalid,
    input  logic                         S_AXIS_6_tvalid,
    input  logic                         enable,
    input  logic [15:0]                  decim_len,
    input  logic [4:0]                   avg_shift,
    output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                         M_AXIS_tvalid,
    input  logic                         M_AXIS_tready,
    output logic                         M_AXIS_tlast,
    output logic [15:0]                  overrun_count
);

    logic [SAXIS_TDATA_WIDTH-1:0] ch   [NUM_CH];
    logic [MAXIS_TDATA_WIDTH-1:0] hold [NUM_CH];
    logic [MAXIS_TDATA_WIDTH-1:0] word;
    logic [15:0]                  cnt;
    logic [15:0]                  target;
    logic [BEAT_W-1:0]            beat;
    state_t                       state;
    logic accept, complete, last_hs, free, load;
    logic unused_tvalid;

    assign ch[0] = S_AXIS_1_tdata;
    assign ch[1] = S_AXIS_2_tdata;
    assign ch[2] = S_AXIS_3_tdata;
    assign ch[3] = S_AXIS_4_tdata;
    assign ch[4] = S_AXIS_5_tdata;
    assign ch[5] = S_AXIS_6_tdata;

    assign unused_tvalid = ^{S_AXIS_2_tvalid, S_AXIS_3_tvalid,
                             S_AXIS_4_tvalid, S_AXIS_5_tvalid,
                             S_AXIS_6_tvalid};

    assign target   = (decim_len == 16'd0) ? 16'd1 : decim_len;
    assign accept   = enable & S_AXIS_1_tvalid;
    assign complete = accept && (({1'b0, cnt} + 17'd1) >= {1'b0, target});
    assign last_hs  = (state == EMIT) && M_AXIS_tready
                   && (beat == BEAT_W'(PKT_LEN-1));
    // A block may land in the holding buffer only when it is empty or draining its last word.
    assign free = (state == IDLE) || last_hs;
    assign load = complete && free;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        axis_avg_lane #(
            .IN_WIDTH (SAXIS_TDATA_WIDTH),
            .OUT_WIDTH(MAXIS_TDATA_WIDTH),
            .ACC_WIDTH(ACC_WIDTH)
        ) u_lane (
            .clk     (a_clk),
            .resetn  (a_resetn),
            .clear   (!enable),
            .accept  (accept),
            .complete(complete),
            .load    (load),
            .shift   (avg_shift),
            .din     (ch[c]),
            .hold    (hold[c])
        );
    end

`ifdef AXIS_AVG_TIMESTAMP_EN
    localparam int OFS = 1;
    logic [31:0] blk_cnt;
    logic [31:0] ts_hold;

    always_ff @(posedge a_clk) begin
        if (!a_resetn) begin
            blk_cnt <= '0;
            ts_hold <= '0;
        end else if (complete) begin
            blk_cnt <= blk_cnt + 32'd1;
            if (load) begin
                ts_hold <= blk_cnt;
            end
        end
    end
`else
    localparam int OFS = 0;
`endif

    always_comb begin
        word = '0;
`ifdef AXIS_AVG_TIMESTAMP_EN
        if (beat == '0) begin
            word = MAXIS_TDATA_WIDTH'(ts_hold);
        end
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (beat == BEAT_W'(i + OFS)) begin
                word = hold[i];
            end
        end
    end

    assign M_AXIS_tdata = M_AXIS_tvalid ? word : '0;

    always_ff @(posedge a_clk) begin
        if (!a_resetn) begin
            cnt           <= '0;
            overrun_count <= '0;
        end else begin
            if (!enable || complete) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + 16'd1;
            end
            if (complete && !free && overrun_count != 16'hFFFF) begin
                overrun_count <= overrun_count + 16'd1;
            end
        end
    end

    always_ff @(posedge a_clk) begin
        if (!a_resetn) begin
            state         <= IDLE;
            beat          <= '0;
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tlast  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load) begin
                        state         <= EMIT;
                        beat          <= '0;
                        M_AXIS_tvalid <= 1'b1;
                        M_AXIS_tlast  <= 1'b0;
                    end
                end
                EMIT: begin
                    if (last_hs) begin
                        beat         <= '0;
                        M_AXIS_tlast <= 1'b0;
                        if (!load) begin
                            state         <= IDLE;
                            M_AXIS_tvalid <= 1'b0;
                        end
                    end else if (M_AXIS_tready) begin
                        beat         <= beat + 1'b1;
                        M_AXIS_tlast <= (beat == BEAT_W'(PKT_LEN-2));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_channel_averager.sv
// Directed bench for axis_channel_averager; default build runs the 6-word tests,
// AXIS_AVG_TIMESTAMP_EN build runs the timestamp test.
module tb_axis_channel_averager;

    logic        a_clk = 1'b0;
    logic        a_resetn;
    logic [31:0] d1, d2, d3, d4, d5, d6;
    logic        s_tvalid;
    logic        enable;
    logic [15:0] decim_len;
    logic [4:0]  avg_shift;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [15:0] overrun_count;

    int errors = 0;
    int checks = 0;

    always #5 a_clk = ~a_clk;

    axis_channel_averager dut (
        .a_clk          (a_clk),
        .a_resetn       (a_resetn),
        .S_AXIS_1_tdata (d1),
        .S_AXIS_2_tdata (d2),
        .S_AXIS_3_tdata (d3),
        .S_AXIS_4_tdata (d4),
        .S_AXIS_5_tdata (d5),
        .S_AXIS_6_tdata (d6),
        .S_AXIS_1_tvalid(s_tvalid),
        .S_AXIS_2_tvalid(s_tvalid),
        .S_AXIS_3_tvalid(s_tvalid),
        .S_AXIS_4_tvalid(s_tvalid),
        .S_AXIS_5_tvalid(s_tvalid),
        .S_AXIS_6_tvalid(s_tvalid),
        .enable         (enable),
        .decim_len      (decim_len),
        .avg_shift      (avg_shift),
        .M_AXIS_tdata   (m_tdata),
        .M_AXIS_tvalid  (m_tvalid),
        .M_AXIS_tready  (m_tready),
        .M_AXIS_tlast   (m_tlast),
        .overrun_count  (overrun_count)
    );

    task automatic tick();
        @(posedge a_clk);
        #1;
    endtask

    task automatic set_ch(input logic [31:0] a, b, c, d, e, f);
        d1 = a; d2 = b; d3 = c; d4 = d; d5 = e; d6 = f;
    endtask

    task automatic apply_reset();
        a_resetn = 1'b0;
        s_tvalid = 1'b0;
        enable = 1'b1;
        m_tready = 1'b1;
        decim_len = 16'd1;
        avg_shift = 5'd0;
        set_ch(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        a_resetn = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 32'h0
            || overrun_count !== 16'h0) begin
            errors++;
            $display("FAIL reset: got v=%b l=%b d=%h ov=%h want 0/0/0/0",
                     m_tvalid, m_tlast, m_tdata, overrun_count);
        end
    endtask

`ifndef AXIS_AVG_TIMESTAMP_EN
    task automatic test_average();
        logic [31:0] exp [6];
        exp = '{32'd100, 32'd200, 32'hFFFF_FF9C, 32'd0, 32'd7, 32'h7FFF_FFFF};
        apply_reset();
        decim_len = 16'd4;
        avg_shift = 5'd2;
        set_ch(32'd100, 32'd200, 32'hFFFF_FF9C, 32'd0, 32'd7, 32'h7FFF_FFFF);
        s_tvalid = 1'b1;
        repeat (3) tick();
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL avg_early: tvalid=%b want 0", m_tvalid);
        end
        tick();
        s_tvalid = 1'b0;
        for (int b = 0; b < 6; b++) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== exp[b] || m_tlast !== (b == 5)) begin
                errors++;
                $display("FAIL avg_word%0d: got v=%b d=%h l=%b want 1/%h/%b",
                         b, m_tvalid, m_tdata, m_tlast, exp[b], b == 5);
            end
            tick();
        end
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL avg_idle: tvalid=%b want 0", m_tvalid);
        end
    endtask

    task automatic test_overrun();
        apply_reset();
        decim_len = 16'd1;
        avg_shift = 5'd0;
        set_ch(32'h7FFF_FFFF, 0, 0, 0, 0, 0);
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        tick();
        tick();
        s_tvalid = 1'b0;
        repeat (3) tick();
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h7FFF_FFFF || m_tlast !== 1'b0
            || overrun_count !== 16'd1) begin
            errors++;
            $display("FAIL ovr_hold: got v=%b d=%h l=%b ov=%0d want 1/7fffffff/0/1",
                     m_tvalid, m_tdata, m_tlast, overrun_count);
        end
        m_tready = 1'b1;
        for (int b = 0; b < 6; b++) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tlast !== (b == 5)
                || m_tdata !== ((b == 0) ? 32'h7FFF_FFFF : 32'h0)) begin
                errors++;
                $display("FAIL ovr_word%0d: got v=%b d=%h l=%b", b, m_tvalid, m_tdata, m_tlast);
            end
            tick();
        end
        checks++;
        if (m_tvalid !== 1'b0 || overrun_count !== 16'd1) begin
            errors++;
            $display("FAIL ovr_end: got v=%b ov=%0d want 0/1", m_tvalid, overrun_count);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        apply_reset();
        decim_len = 16'd6;
        avg_shift = 5'd0;
        set_ch(32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60);
        s_tvalid = 1'b1;
        repeat (6) tick();
        bad = 0;
        for (int k = 0; k < 18; k++) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== 32'(60 * ((k % 6) + 1))
                || m_tlast !== ((k % 6) == 5)) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got v=%b d=%0d l=%b want 1/%0d/%b",
                         k, m_tvalid, m_tdata, m_tlast, 60 * ((k % 6) + 1), (k % 6) == 5);
            end
            tick();
        end
        s_tvalid = 1'b0;
        checks++;
        if (overrun_count !== 16'd0) begin
            errors++;
            $display("FAIL b2b_overrun: got %0d want 0", overrun_count);
        end
    endtask

    task automatic test_enable();
        apply_reset();
        decim_len = 16'd8;
        avg_shift = 5'd3;
        set_ch(1000, 1000, 1000, 1000, 1000, 1000);
        s_tvalid = 1'b1;
        tick();
        tick();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        set_ch(1, 1, 1, 1, 1, 1);
        repeat (7) tick();
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL en_early: tvalid=%b want 0", m_tvalid);
        end
        tick();
        s_tvalid = 1'b0;
        for (int b = 0; b < 6; b++) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== 32'd1 || m_tlast !== (b == 5)) begin
                errors++;
                $display("FAIL en_word%0d: got v=%b d=%0d l=%b want 1/1/%b",
                         b, m_tvalid, m_tdata, m_tlast, b == 5);
            end
            tick();
        end
    endtask

    task automatic test_reset_midpacket();
        apply_reset();
        decim_len = 16'd1;
        avg_shift = 5'd0;
        set_ch(1, 2, 3, 4, 5, 6);
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        repeat (3) tick();
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'd4) begin
            errors++;
            $display("FAIL rst_beat3: got v=%b d=%0d want 1/4", m_tvalid, m_tdata);
        end
        a_resetn = 1'b0;
        tick();
        checks++;
        if (m_tvalid !== 1'b0 || overrun_count !== 16'd0 || m_tdata !== 32'd0
            || m_tlast !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got v=%b ov=%0d d=%h l=%b want 0/0/0/0",
                     m_tvalid, overrun_count, m_tdata, m_tlast);
        end
        a_resetn = 1'b1;
        set_ch(11, 12, 13, 14, 15, 16);
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        for (int b = 0; b < 6; b++) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== 32'(11 + b) || m_tlast !== (b == 5)) begin
                errors++;
                $display("FAIL rst_word%0d: got v=%b d=%0d l=%b want 1/%0d/%b",
                         b, m_tvalid, m_tdata, m_tlast, 11 + b, b == 5);
            end
            tick();
        end
    endtask

    task automatic test_decim_zero();
        apply_reset();
        decim_len = 16'd0;
        avg_shift = 5'd0;
        set_ch(5, 5, 5, 5, 5, 5);
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'd5) begin
            errors++;
            $display("FAIL dz_first: got v=%b d=%0d want 1/5", m_tvalid, m_tdata);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] exp [6];
        exp = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFA,
                32'hFFFF_FFFE, 32'h0, 32'h7FFF_FFFF};
        apply_reset();
        decim_len = 16'd2;
        avg_shift = 5'd0;
        set_ch(32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFD,
               32'hFFFF_FFFF, 32'h0, 32'h4000_0000);
        s_tvalid = 1'b1;
        tick();
        tick();
        s_tvalid = 1'b0;
        for (int b = 0; b < 6; b++) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== exp[b]) begin
                errors++;
                $display("FAIL sat_word%0d: got v=%b d=%h want 1/%h",
                         b, m_tvalid, m_tdata, exp[b]);
            end
            tick();
        end
    endtask
`else
    task automatic test_timestamp();
        apply_reset();
        decim_len = 16'd1;
        avg_shift = 5'd0;
        set_ch(1, 2, 3, 4, 5, 6);
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        tick();
        tick();
        s_tvalid = 1'b0;
        checks++;
        if (overrun_count !== 16'd1) begin
            errors++;
            $display("FAIL ts_overrun: got %0d want 1", overrun_count);
        end
        m_tready = 1'b1;
        for (int b = 0; b < 7; b++) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== 32'(b) || m_tlast !== (b == 6)) begin
                errors++;
                $display("FAIL ts_pkt1_word%0d: got v=%b d=%0d l=%b want 1/%0d/%b",
                         b, m_tvalid, m_tdata, m_tlast, b, b == 6);
            end
            tick();
        end
        set_ch(21, 22, 23, 24, 25, 26);
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        for (int b = 0; b < 7; b++) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tlast !== (b == 6)
                || m_tdata !== ((b == 0) ? 32'd2 : 32'(20 + b))) begin
                errors++;
                $display("FAIL ts_pkt2_word%0d: got v=%b d=%0d l=%b",
                         b, m_tvalid, m_tdata, m_tlast);
            end
            tick();
        end
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL ts_idle: tvalid=%b want 0", m_tvalid);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifndef AXIS_AVG_TIMESTAMP_EN
        test_average();
        test_overrun();
        test_back_to_back();
        test_enable();
        test_reset_midpacket();
        test_decim_zero();
        test_saturation();
`else
        test_timestamp();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
